// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable, plus auto-scan up/down
// with programmable dwell and a retriggerable one-shot pulse mode.
module scan_decoder #(
  parameter int N       = 2,
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [N-1:0]         sel,
  input  logic                 load,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [(1<<N)-1:0]    y,
  output logic [N-1:0]         idx,
  output logic                 wrap,
  output logic                 busy
);

  localparam int OUT_W = 1 << N;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_PULSE     = 2'b11
  } mode_e;

  function automatic logic [OUT_W-1:0] onehot(input logic [N-1:0] v);
    logic [OUT_W-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  mode_e              mode_cur;
  mode_e              prev_mode;
  logic [DWELL_W-1:0] dwell_reg;
  logic [DWELL_W-1:0] cnt;

  logic [OUT_W-1:0]   y_n;
  logic [N-1:0]       idx_n;
  logic               wrap_n;
  logic               busy_n;
  logic [DWELL_W-1:0] dwell_n;
  logic [DWELL_W-1:0] cnt_n;

  logic               mode_chg;
  logic [DWELL_W-1:0] cnt_eff;
  logic               busy_eff;
  logic               step_due;

  assign mode_cur = mode_e'(mode);
  assign mode_chg = (mode_cur != prev_mode);

  // A mode change clears timing state before the new mode acts on this edge.
  assign cnt_eff  = mode_chg ? '0 : cnt;
  assign busy_eff = mode_chg ? 1'b0 : busy;
  // >= keeps cnt bounded even if dwell_reg was lowered while cnt was running.
  assign step_due = (cnt_eff >= dwell_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y         <= '0;
      idx       <= '0;
      wrap      <= 1'b0;
      busy      <= 1'b0;
      dwell_reg <= '0;
      cnt       <= '0;
      prev_mode <= MODE_DIRECT;
    end else begin
      y         <= y_n;
      idx       <= idx_n;
      wrap      <= wrap_n;
      busy      <= busy_n;
      dwell_reg <= dwell_n;
      cnt       <= cnt_n;
      prev_mode <= mode_cur;
    end
  end

  always_comb begin
    y_n     = y;
    idx_n   = idx;
    wrap_n  = 1'b0;
    busy_n  = 1'b0;
    dwell_n = dwell_reg;
    cnt_n   = '0;

    if (!en) begin
      y_n = '0;
    end else begin
      case (mode_cur)
        MODE_DIRECT: begin
          idx_n = sel;
          y_n   = onehot(sel);
          if (load) dwell_n = dwell;
        end

        MODE_SCAN_UP, MODE_SCAN_DOWN: begin
          if (load) begin
            idx_n   = sel;
            dwell_n = dwell;
          end else if (step_due) begin
            if (mode_cur == MODE_SCAN_UP) begin
              idx_n  = idx + 1'b1;
              wrap_n = (idx == {N{1'b1}});
            end else begin
              idx_n  = idx - 1'b1;
              wrap_n = (idx == {N{1'b0}});
            end
          end else begin
            cnt_n = cnt_eff + 1'b1;
          end
          // y follows the index that is being registered this edge.
          y_n = onehot(idx_n);
        end

        MODE_PULSE: begin
          if (load) begin
            idx_n   = sel;
            dwell_n = dwell;
            y_n     = onehot(sel);
            busy_n  = 1'b1;
          end else if (busy_eff && !step_due) begin
            cnt_n  = cnt_eff + 1'b1;
            busy_n = 1'b1;
            y_n    = onehot(idx);
          end else begin
            y_n = '0;
          end
        end

        default: begin
          y_n = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (N=2): decode, scan up/down, pulse,
// retrigger, reset mid-scan, mode change and enable gating.
module tb_scan_decoder;

  localparam int N       = 2;
  localparam int DWELL_W = 4;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic [1:0]         mode;
  logic [N-1:0]       sel;
  logic               load;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         y;
  logic [N-1:0]       idx;
  logic               wrap;
  logic               busy;

  int n_cmp  = 0;
  int n_fail = 0;

  scan_decoder #(.N(N), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .sel   (sel),
    .load  (load),
    .dwell (dwell),
    .y     (y),
    .idx   (idx),
    .wrap  (wrap),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (y !== 4'b0000) begin n_fail++; $display("FAIL reset_y: got %b want 0000", y); end
    n_cmp++; if (idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", idx); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_direct();
    logic [3:0] exp_y [4];
    exp_y = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = 2'b00;
    for (int i = 0; i < 4; i++) begin
      sel = i[N-1:0];
      tick();
      n_cmp++; if (y !== exp_y[i]) begin n_fail++; $display("FAIL direct_y[%0d]: got %b want %b", i, y, exp_y[i]); end
      n_cmp++; if (idx !== i[N-1:0]) begin n_fail++; $display("FAIL direct_idx[%0d]: got %0d want %0d", i, idx, i); end
    end
    en = 1'b0;
    tick();
    n_cmp++; if (y !== 4'b0000) begin n_fail++; $display("FAIL direct_en0_y: got %b want 0000", y); end
    n_cmp++; if (idx !== 2'd3) begin n_fail++; $display("FAIL direct_en0_idx: got %0d want 3", idx); end
  endtask

  task automatic test_scan_up();
    logic [3:0] exp_y [8];
    logic       exp_w [8];
    exp_y = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    en    = 1'b1;
    mode  = 2'b01;
    sel   = 2'd2;
    dwell = 4'd1;
    load  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      load = 1'b0;
      n_cmp++; if (y !== exp_y[i]) begin n_fail++; $display("FAIL up_y[%0d]: got %b want %b", i, y, exp_y[i]); end
      n_cmp++; if (wrap !== exp_w[i]) begin n_fail++; $display("FAIL up_wrap[%0d]: got %b want %b", i, wrap, exp_w[i]); end
    end
  endtask

  task automatic test_scan_down();
    logic [3:0] exp_y [6];
    logic       exp_w [6];
    exp_y = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    mode  = 2'b10;
    sel   = 2'd0;
    dwell = 4'd0;
    load  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      load = 1'b0;
      n_cmp++; if (y !== exp_y[i]) begin n_fail++; $display("FAIL down_y[%0d]: got %b want %b", i, y, exp_y[i]); end
      n_cmp++; if (wrap !== exp_w[i]) begin n_fail++; $display("FAIL down_wrap[%0d]: got %b want %b", i, wrap, exp_w[i]); end
    end
  endtask

  task automatic test_pulse();
    mode  = 2'b11;
    sel   = 2'd1;
    dwell = 4'd3;
    load  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      load = 1'b0;
      if (i < 4) begin
        n_cmp++; if (y !== 4'b0010) begin n_fail++; $display("FAIL pulse_y[%0d]: got %b want 0010", i, y); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pulse_busy[%0d]: got %b want 1", i, busy); end
      end else begin
        n_cmp++; if (y !== 4'b0000) begin n_fail++; $display("FAIL pulse_y[%0d]: got %b want 0000", i, y); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pulse_busy[%0d]: got %b want 0", i, busy); end
      end
    end
  endtask

  task automatic test_retrigger();
    sel   = 2'd1;
    dwell = 4'd3;
    load  = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++; if (y !== 4'b0010) begin n_fail++; $display("FAIL retrig_first_y: got %b want 0010", y); end
    tick();
    n_cmp++; if (y !== 4'b0010) begin n_fail++; $display("FAIL retrig_first_y1: got %b want 0010", y); end
    sel  = 2'd3;
    load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      load = 1'b0;
      if (i < 4) begin
        n_cmp++; if (y !== 4'b1000) begin n_fail++; $display("FAIL retrig_y[%0d]: got %b want 1000", i, y); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL retrig_busy[%0d]: got %b want 1", i, busy); end
      end else begin
        n_cmp++; if (y !== 4'b0000) begin n_fail++; $display("FAIL retrig_y[%0d]: got %b want 0000", i, y); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL retrig_busy[%0d]: got %b want 0", i, busy); end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [3:0] exp_y [4];
    logic       exp_w [4];
    exp_y = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b1};
    mode  = 2'b01;
    sel   = 2'd2;
    dwell = 4'd3;
    load  = 1'b1;
    tick();
    load = 1'b0;
    tick();
    n_cmp++; if (idx !== 2'd2) begin n_fail++; $display("FAIL midscan_pre_idx: got %0d want 2", idx); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (y !== 4'b0000) begin n_fail++; $display("FAIL midscan_rst_y: got %b want 0000", y); end
    n_cmp++; if (idx !== 2'd0) begin n_fail++; $display("FAIL midscan_rst_idx: got %0d want 0", idx); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL midscan_rst_wrap: got %b want 0", wrap); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midscan_rst_busy: got %b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (y !== exp_y[i]) begin n_fail++; $display("FAIL midscan_y[%0d]: got %b want %b", i, y, exp_y[i]); end
      n_cmp++; if (wrap !== exp_w[i]) begin n_fail++; $display("FAIL midscan_wrap[%0d]: got %b want %b", i, wrap, exp_w[i]); end
    end
  endtask

  task automatic test_mode_change();
    mode = 2'b11;
    tick();
    n_cmp++; if (y !== 4'b0000) begin n_fail++; $display("FAIL modechg_y: got %b want 0000", y); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL modechg_busy: got %b want 0", busy); end
    n_cmp++; if (idx !== 2'd0) begin n_fail++; $display("FAIL modechg_idx: got %0d want 0", idx); end
    en    = 1'b0;
    sel   = 2'd3;
    dwell = 4'd5;
    load  = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++; if (idx !== 2'd0) begin n_fail++; $display("FAIL en0_load_idx: got %0d want 0", idx); end
    n_cmp++; if (y !== 4'b0000) begin n_fail++; $display("FAIL en0_load_y: got %b want 0000", y); end
    en = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en0_load_busy: got %b want 0", busy); end
    n_cmp++; if (y !== 4'b0000) begin n_fail++; $display("FAIL en0_load_y2: got %b want 0000", y); end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    sel   = '0;
    load  = 1'b0;
    dwell = '0;
    test_reset();
    test_direct();
    test_scan_up();
    test_scan_down();
    test_pulse();
    test_retrigger();
    test_reset_mid_scan();
    test_mode_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
